// File: rtl/db_multi.sv
// Multi-channel switch debouncer: per-channel synchroniser and a four-state debounce FSM
// that shares one sample-tick divider, with registered rise/fall pulses per channel.
module db_multi #(
  parameter int CH           = 4,
  parameter int TICK_DIV     = 500000,
  parameter int STABLE_TICKS = 3,
  parameter int SYNC_STAGES  = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [CH-1:0] sw,
  output logic [CH-1:0] db,
  output logic [CH-1:0] rise,
  output logic [CH-1:0] fall,
  output logic          tick
);

  localparam int TW = $clog2(TICK_DIV);
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(STABLE_TICKS - 1);

  localparam logic [1:0] ZERO  = 2'd0;
  localparam logic [1:0] WAIT1 = 2'd1;
  localparam logic [1:0] ONE   = 2'd2;
  localparam logic [1:0] WAIT0 = 2'd3;

  logic [CH-1:0][SYNC_STAGES-1:0] sync_q;
  logic [CH-1:0]                  s;
  logic [TW-1:0]                  tick_cnt;
  logic [CH-1:0][1:0]             state_q, state_d;
  logic [CH-1:0][CW-1:0]          cnt_q, cnt_d;
  logic [CH-1:0]                  rise_d, fall_d;

  // NOTE: every clocked block uses non-blocking assignments so all flops update
  // from the same pre-edge values; blocking here would collapse the sync chain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], sw[i]};
      end
    end
  end

  always_comb begin
    s = '0;
    for (int i = 0; i < CH; i++) begin
      s[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign tick = (tick_cnt == TICK_LAST);

  // NOTE: each output of this block gets a default before the case so that no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rise_d  = '0;
    fall_d  = '0;
    for (int i = 0; i < CH; i++) begin
      case (state_q[i])
        ZERO: begin
          if (s[i]) begin
            state_d[i] = WAIT1;
            cnt_d[i]   = '0;
          end
        end
        WAIT1: begin
          // Returning to the old level wins over a coincident tick.
          if (!s[i]) begin
            state_d[i] = ZERO;
          end else if (tick) begin
            if (cnt_q[i] == CNT_LAST) begin
              state_d[i] = ONE;
              rise_d[i]  = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
        end
        ONE: begin
          if (!s[i]) begin
            state_d[i] = WAIT0;
            cnt_d[i]   = '0;
          end
        end
        WAIT0: begin
          if (s[i]) begin
            state_d[i] = ONE;
          end else if (tick) begin
            if (cnt_q[i] == CNT_LAST) begin
              state_d[i] = ZERO;
              fall_d[i]  = 1'b1;
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
        end
        default: begin
          state_d[i] = ZERO;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= ZERO;
      end
      cnt_q <= '0;
      rise  <= '0;
      fall  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rise    <= rise_d;
      fall    <= fall_d;
    end
  end

  // Moore decode: the debounced level comes only from the state register.
  always_comb begin
    db = '0;
    for (int i = 0; i < CH; i++) begin
      db[i] = (state_q[i] == ONE) || (state_q[i] == WAIT0);
    end
  end

endmodule

// File: tb/tb_db_multi.sv
// Self-checking bench for db_multi (CH=2, TICK_DIV=4, STABLE_TICKS=3, SYNC_STAGES=2):
// table of held input levels with a scoreboard queue, plus latency and reset sequences.
module tb_db_multi;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] sw = 2'b00;
  logic [1:0] db, rise, fall;
  logic       tick;

  int n_pass = 0;
  int n_total = 0;
  int n_overlap = 0;

  typedef struct {
    logic [1:0] db;
    int r0, r1, f0, f1;
  } exp_t;

  typedef struct {
    logic [1:0] sw;
    int         cyc;
    exp_t       exp;
  } vec_t;

  exp_t sb_q[$];
  vec_t vecs[13];

  db_multi #(
    .CH(2), .TICK_DIV(4), .STABLE_TICKS(3), .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .db(db), .rise(rise), .fall(fall), .tick(tick)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!reset && (|(rise & fall))) n_overlap++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  function automatic vec_t mk(input logic [1:0] s, input int c, input logic [1:0] d,
                              input int r0, input int r1, input int f0, input int f1);
    vec_t v;
    v.sw = s; v.cyc = c; v.exp.db = d;
    v.exp.r0 = r0; v.exp.r1 = r1; v.exp.f0 = f0; v.exp.f1 = f1;
    return v;
  endfunction

  function automatic logic [31:0] pack(input logic [1:0] d, input int r0, input int r1,
                                       input int f0, input int f1);
    return {14'b0, d, 4'(r0), 4'(r1), 4'(f0), 4'(f1)};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sw = 2'b00;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Runs up to max_edges edges; lat = first edge index where db[ch]=1 (-1 if never).
  task automatic measure(input int max_edges, input int ch, output int lat,
                         output int rcnt, output int other);
    lat = -1; rcnt = 0; other = 0;
    for (int n = 0; n < max_edges; n++) begin
      @(posedge clk); #1;
      if (db[ch] && lat < 0) lat = n;
      if (rise[ch]) rcnt++;
      if (db[ch^1] || rise[ch^1] || (|fall)) other++;
    end
  endtask

  initial begin
    int lat, rcnt, other, exp_lat, j, mism, ticks, tk, r0, r1, f0, f1;
    logic t, reached;
    exp_t e;

    #2;
    check("reset_state", {28'b0, db, rise, fall, tick} >> 0, 32'h0);

    // Tick period and phase over 100 periods after release.
    do_reset();
    mism = 0; ticks = 0;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (tick !== ((k % 4) == 3)) mism++;
      if (tick) ticks++;
    end
    check("tick_phase_errors", mism, 0);
    check("tick_count", ticks, 100);

    // Rise latency for each tick phase; exact edge from the tick schedule.
    for (int p = 0; p < 4; p++) begin
      do_reset();
      repeat (p) @(negedge clk);
      sw = 2'b01;
      j = 4 * ((p + 3) / 4 + 1);
      exp_lat = j - (p + 1) + 8;
      measure(40, 0, lat, rcnt, other);
      check($sformatf("lat_phase%0d", p), lat, exp_lat);
      check($sformatf("rise0_count_phase%0d", p), rcnt, 1);
      check($sformatf("ch1_quiet_phase%0d", p), other, 0);
    end

    // Table of held levels; expectations queued at drive time, compared at window end.
    vecs[0]  = mk(2'b00, 20, 2'b00, 0, 0, 0, 0);
    vecs[1]  = mk(2'b01,  5, 2'b00, 0, 0, 0, 0);
    vecs[2]  = mk(2'b00, 20, 2'b00, 0, 0, 0, 0);
    vecs[3]  = mk(2'b01, 20, 2'b01, 1, 0, 0, 0);
    vecs[4]  = mk(2'b00,  6, 2'b01, 0, 0, 0, 0);
    vecs[5]  = mk(2'b01, 20, 2'b01, 0, 0, 0, 0);
    vecs[6]  = mk(2'b00, 15, 2'b00, 0, 0, 1, 0);
    vecs[7]  = mk(2'b11, 20, 2'b11, 1, 1, 0, 0);
    vecs[8]  = mk(2'b10, 20, 2'b10, 0, 0, 1, 0);
    vecs[9]  = mk(2'b01, 20, 2'b01, 1, 0, 0, 1);
    vecs[10] = mk(2'b00,  9, 2'b01, 0, 0, 0, 0);
    vecs[11] = mk(2'b01, 20, 2'b01, 0, 0, 0, 0);
    vecs[12] = mk(2'b00, 20, 2'b00, 0, 0, 1, 0);
    do_reset();
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      sw = vecs[i].sw;
      sb_q.push_back(vecs[i].exp);
      r0 = 0; r1 = 0; f0 = 0; f1 = 0;
      for (int n = 0; n < vecs[i].cyc; n++) begin
        @(posedge clk); #1;
        r0 += int'(rise[0]); r1 += int'(rise[1]);
        f0 += int'(fall[0]); f1 += int'(fall[1]);
      end
      e = sb_q.pop_front();
      check($sformatf("vec%0d", i), pack(db, r0, r1, f0, f1),
            pack(e.db, e.r0, e.r1, e.f0, e.f1));
    end

    // Both channels switched together must assert on the same edge.
    do_reset();
    sw = 2'b11;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (db != 2'b00) break;
    end
    check("both_db_same_cycle", db, 2'b11);
    check("both_rise_same_cycle", rise, 2'b11);
    @(posedge clk); #1;
    check("both_rise_single_cycle", {db, rise}, 4'b1100);

    // Reset while channel 0 sits in WAIT0 with two ticks counted.
    do_reset();
    sw = 2'b01;
    repeat (20) @(posedge clk);
    @(negedge clk);
    sw = 2'b00;
    tk = 0; reached = 1'b0;
    for (int n = 0; n < 30; n++) begin
      t = tick;
      @(posedge clk); #1;
      if (n >= 3 && t) tk++;
      if (tk == 2) begin
        reached = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("wait0_cnt2_reached", reached, 1'b1);
    check("db_before_reset", db[0], 1'b1);
    reset = 1'b1;
    #1;
    check("reset_immediate", {db, rise, fall, tick}, 7'b0);
    @(negedge clk);
    reset = 1'b0;
    sw = 2'b01;
    measure(40, 0, lat, rcnt, other);
    check("post_reset_lat_in_range", (lat >= 11 && lat <= 14), 1'b1);
    check("post_reset_rise_once", rcnt, 1);
    check("post_reset_no_fall", other, 0);

    check("rise_fall_overlap", n_overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
